// File: rtl/int_div_arbiter.sv
// int_div_arbiter
// Shares one iterative integer divider between N_REQ requesters. Grants are
// round-robin and only one operation is in flight at a time. The divider
// result and the owner's tag go back to the owning requester only.
//
// Handshake rule on every valid/ready pair (req_*, rsp_*, div_*, div_res_*):
// a transfer happens on the rising clk edge where valid and ready are both 1.
// The source holds valid and payload stable until that edge and does not
// withdraw valid early. The sink may raise or drop ready freely.
//
// The block never inspects operands. Divide-by-zero, overflow, sign handling
// and any DIV/REM result reuse inside the divider pass through untouched.
module int_div_arbiter #(
    parameter int N_REQ = 2,
    parameter int n     = 32,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [n*N_REQ-1:0]     req_a,
    input  logic [n*N_REQ-1:0]     req_b,
    input  logic [TAG_W*N_REQ-1:0] req_tag,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [n-1:0]           rsp_y,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   div_valid,
    input  logic                   div_ready,
    output logic [1:0]             div_op,
    output logic [n-1:0]           div_a,
    output logic [n-1:0]           div_b,
    input  logic                   div_res_valid,
    output logic                   div_res_ready,
    input  logic [n-1:0]           div_y,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   owner_q;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [1:0]         sel_op;
    logic [n-1:0]       sel_a;
    logic [n-1:0]       sel_b;
    logic [TAG_W-1:0]   sel_tag;

    logic               accept;
    logic               take;
    logic               done;

    assign dbg_state = state_q;

    // Round-robin search: first valid index at or above rr, then wrap to the
    // lowest valid index below rr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDX_W'(i) >= rr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    // Payload of the granted requester, picked from the packed request buses.
    always_comb begin
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_op  = req_op[2*i +: 2];
                sel_a   = req_a[n*i +: n];
                sel_b   = req_b[n*i +: n];
                sel_tag = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        req_ready     = '0;
        rsp_valid     = '0;
        div_valid     = 1'b0;
        div_res_ready = 1'b0;
        accept        = 1'b0;
        take          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Gated by reset so nothing reads as accepted while in reset.
                if (grant_found && !reset) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready[i] = (IDX_W'(i) == grant_idx);
                    end
                end
            end
            ST_ISSUE: begin
                // Result side is already open so the divider is free to
                // accept operands.
                div_valid     = 1'b1;
                div_res_ready = 1'b1;
                if (div_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                div_res_ready = 1'b1;
                if (div_res_valid) begin
                    take    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                for (int i = 0; i < N_REQ; i++) begin
                    rsp_valid[i] = (IDX_W'(i) == owner_q);
                end
                if (rsp_ready[owner_q]) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, tag and result capture, owner tracking and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_op  <= '0;
            div_a   <= '0;
            div_b   <= '0;
            rsp_tag <= '0;
            rsp_y   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            if (accept) begin
                div_op  <= sel_op;
                div_a   <= sel_a;
                div_b   <= sel_b;
                rsp_tag <= sel_tag;
                owner_q <= grant_idx;
            end
            if (take) begin
                rsp_y <= div_y;
            end
            if (done) begin
                rr_q <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
        end
    end

    // Structural invariants of the grant and response paths.
    a_req_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
    a_div_valid_issue:  assert property (@(posedge clk) disable iff (reset) div_valid |-> (state_q == ST_ISSUE));

endmodule
